// File: rtl/sram_rw_init_bytemask.sv
// Single-port SRAM with per-byte write mask, optional output register, read-valid
// strobe and a zero-fill sequencer that runs after reset or on clr0.
module sram_rw_init_bytemask #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                      clk0,
    input  logic                      rst_n0,
    input  logic                      csb0,
    input  logic                      web0,
    input  logic [DATA_WIDTH/8-1:0]   wmask0,
    input  logic [ADDR_WIDTH-1:0]     addr0,
    input  logic [DATA_WIDTH-1:0]     din0,
    input  logic                      clr0,
    output logic                      ready0,
    output logic [DATA_WIDTH-1:0]     dout0,
    output logic                      dout_valid0,
    output logic                      init_done0
);
    localparam int WMASK_WIDTH = DATA_WIDTH / 8;
    localparam int RAM_DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    // state   | meaning
    // S_INIT  | zero-filling one word per cycle, accesses ignored
    // S_READY | accesses accepted when csb0 is low
    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_e;

    localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_READY;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
    logic                    rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    accept, rd_acc, wr_acc;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    assign accept     = (state_q == S_READY) && !csb0;
    assign rd_acc     = accept && web0;
    assign wr_acc     = accept && !web0;
    assign ready0     = (state_q == S_READY);
    assign init_done0 = (state_q == S_READY);

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        case (state_q)
            S_INIT: begin
                if (init_addr_q == ADDR_LAST) begin
                    state_d     = S_READY;
                    init_addr_d = '0;
                end else begin
                    init_addr_d = init_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: ;
        endcase
        // clr0 wins in either state; an access accepted alongside it still completes
        if (clr0) begin
            state_d     = S_INIT;
            init_addr_d = '0;
        end
    end

    always_comb begin
        rd_vld_d  = rd_acc;
        rd_data_d = rd_acc ? mem[addr0] : rd_data_q;
    end

    always_ff @(posedge clk0 or negedge rst_n0) begin
        if (!rst_n0) begin
            state_q     <= RST_STATE;
            init_addr_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // The array has no reset; only the fill sequencer clears it.
    always_ff @(posedge clk0) begin
        if (state_q == S_INIT) begin
            mem[init_addr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  out_vld_q, out_vld_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

        always_comb begin
            out_vld_d  = rd_vld_q;
            out_data_d = rd_vld_q ? rd_data_q : out_data_q;
        end

        always_ff @(posedge clk0 or negedge rst_n0) begin
            if (!rst_n0) begin
                out_vld_q  <= 1'b0;
                out_data_q <= '0;
            end else begin
                out_vld_q  <= out_vld_d;
                out_data_q <= out_data_d;
            end
        end

        assign dout0       = out_data_q;
        assign dout_valid0 = out_vld_q;
    end else begin : g_no_out_reg
        assign dout0       = rd_data_q;
        assign dout_valid0 = rd_vld_q;
    end

endmodule

// File: tb/tb_sram_rw_init_bytemask.sv
// Directed bench for sram_rw_init_bytemask: three instances (latency 1, latency 2,
// no init-on-reset) share stimulus and are compared each cycle against a word-level model.
module tb_sram_rw_init_bytemask;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NI    = 3;
    localparam int LAT [NI] = '{1, 2, 1};
    localparam int IOR [NI] = '{1, 1, 0};

    logic          clk0;
    logic          rst_n0;
    logic          csb0, web0, clr0;
    logic [3:0]    wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;

    logic          ready_w      [NI];
    logic          init_done_w  [NI];
    logic          dout_valid_w [NI];
    logic [DW-1:0] dout_w       [NI];

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    sram_rw_init_bytemask #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .INIT_ON_RESET(1)) u_lat1 (
        .clk0(clk0), .rst_n0(rst_n0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .clr0(clr0), .ready0(ready_w[0]), .dout0(dout_w[0]),
        .dout_valid0(dout_valid_w[0]), .init_done0(init_done_w[0]));

    sram_rw_init_bytemask #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .INIT_ON_RESET(1)) u_lat2 (
        .clk0(clk0), .rst_n0(rst_n0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .clr0(clr0), .ready0(ready_w[1]), .dout0(dout_w[1]),
        .dout_valid0(dout_valid_w[1]), .init_done0(init_done_w[1]));

    sram_rw_init_bytemask #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .INIT_ON_RESET(0)) u_noinit (
        .clk0(clk0), .rst_n0(rst_n0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .clr0(clr0), .ready0(ready_w[2]), .dout0(dout_w[2]),
        .dout_valid0(dout_valid_w[2]), .init_done0(init_done_w[2]));

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // model: memory with per-byte known flags, remaining fill cycles, read delivery line
    logic [DW-1:0] mem_m  [NI][DEPTH];
    logic [3:0]    kn_m   [NI][DEPTH];
    int            fill_left [NI];
    logic          st_v [NI];
    logic [DW-1:0] st_d [NI];
    logic [3:0]    st_k [NI];
    logic          ex_v [NI];
    logic [DW-1:0] ex_d [NI];
    logic [3:0]    ex_k [NI];
    logic          acc_m, rv_m;
    logic [DW-1:0] rd_m;
    logic [3:0]    rk_m;

    function automatic logic [DW-1:0] bm(input logic [3:0] k);
        logic [DW-1:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{k[i]}};
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            fill_left[k] = (IOR[k] != 0) ? DEPTH : 0;
            st_v[k] = 1'b0; st_d[k] = '0; st_k[k] = 4'hF;
            ex_v[k] = 1'b0; ex_d[k] = '0; ex_k[k] = 4'hF;
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[k][a] = '0;
                kn_m[k][a]  = 4'h0;
            end
        model_reset();
    end

    always @(posedge clk0 or negedge rst_n0) begin
        if (!rst_n0) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                acc_m = (fill_left[k] == 0) && !csb0;
                rv_m  = acc_m && web0;
                rd_m  = mem_m[k][addr0];
                rk_m  = kn_m[k][addr0];
                if (LAT[k] == 1) begin
                    ex_v[k] = rv_m;
                    if (rv_m) begin ex_d[k] = rd_m; ex_k[k] = rk_m; end
                end else begin
                    ex_v[k] = st_v[k];
                    if (st_v[k]) begin ex_d[k] = st_d[k]; ex_k[k] = st_k[k]; end
                    st_v[k] = rv_m;
                    if (rv_m) begin st_d[k] = rd_m; st_k[k] = rk_m; end
                end
                if (acc_m && !web0)
                    for (int i = 0; i < 4; i++)
                        if (wmask0[i]) begin
                            mem_m[k][addr0][8*i +: 8] = din0[8*i +: 8];
                            kn_m[k][addr0][i] = 1'b1;
                        end
                if (fill_left[k] > 0) begin
                    mem_m[k][DEPTH - fill_left[k]] = '0;
                    kn_m[k][DEPTH - fill_left[k]]  = 4'hF;
                    fill_left[k] = fill_left[k] - 1;
                end
                if (clr0) fill_left[k] = DEPTH;
            end
        end
    end

    task automatic check(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk0) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                check("ready", k, 32'(ready_w[k]), 32'(fill_left[k] == 0));
                check("init_done", k, 32'(init_done_w[k]), 32'(fill_left[k] == 0));
                check("dout_valid", k, 32'(dout_valid_w[k]), 32'(ex_v[k]));
                check("dout", k, dout_w[k] & bm(ex_k[k]), ex_d[k] & bm(ex_k[k]));
            end
        end
    end

    task automatic cyc(input logic c, input logic w, input logic [3:0] m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic cl);
        csb0 = c; web0 = w; wmask0 = m; addr0 = a; din0 = d; clr0 = cl;
        @(negedge clk0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b1, 4'h0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        cyc(1'b0, 1'b0, m, a, d, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(1'b0, 1'b1, 4'h0, a, '0, 1'b0);
    endtask

    task automatic wait_ready(input int n0, input int exp);
        int n;
        n = n0;
        while (ready_w[0] !== 1'b1 && n < 60) begin
            idle();
            n++;
        end
        check("fill_len", 0, 32'(n), 32'(exp));
    endtask

    initial begin
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0; clr0 = 1'b0;
        rst_n0 = 1'b1;
        #1 rst_n0 = 1'b0;
        chk_en = 1'b1;
        @(negedge clk0);
        @(negedge clk0);
        check("rst_ready", 0, 32'(ready_w[0]), 32'd0);
        check("rst_ready", 2, 32'(ready_w[2]), 32'd1);
        check("rst_dout", 1, dout_w[1], 32'h0);

        // reset release: 16-cycle fill, then every word reads zero
        rst_n0 = 1'b1;
        wait_ready(0, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            rd(AW'(a));
            check("init_zero", 0, dout_w[0], 32'h0);
        end
        idle(); idle();

        // byte mask merge
        wr(4'd5, 32'hAABBCCDD, 4'b1111);
        wr(4'd5, 32'h11223344, 4'b0101);
        rd(4'd5);
        check("mask_lat1", 0, dout_w[0], 32'hAA22CC44);
        idle();
        check("mask_lat2", 1, dout_w[1], 32'hAA22CC44);
        check("mask_lat2_v", 1, 32'(dout_valid_w[1]), 32'd1);

        // latency 1 vs 2, output holds on idle
        wr(4'd3, 32'h12345678, 4'hF);
        rd(4'd3);
        check("lat1_v", 0, 32'(dout_valid_w[0]), 32'd1);
        check("lat1_d", 0, dout_w[0], 32'h12345678);
        check("lat2_early", 1, 32'(dout_valid_w[1]), 32'd0);
        idle();
        check("lat1_hold_v", 0, 32'(dout_valid_w[0]), 32'd0);
        check("lat1_hold_d", 0, dout_w[0], 32'h12345678);
        check("lat2_v", 1, 32'(dout_valid_w[1]), 32'd1);
        check("lat2_d", 1, dout_w[1], 32'h12345678);
        idle(); idle();

        // write then immediate read, streamed reads
        wr(4'd7, 32'hDEADBEEF, 4'hF);
        rd(4'd7);
        check("wr_rd", 0, dout_w[0], 32'hDEADBEEF);
        for (int a = 0; a < 4; a++) wr(AW'(a), 32'hC0DE0000 + DW'(a), 4'hF);
        for (int a = 0; a < 4; a++) begin
            rd(AW'(a));
            check("stream_d", 0, dout_w[0], 32'hC0DE0000 + DW'(a));
            check("stream_v", 0, 32'(dout_valid_w[0]), 32'd1);
        end
        idle(); idle();

        // clr0 with a read in the same cycle; write during fill is dropped
        wr(4'd2, 32'h55, 4'hF);
        cyc(1'b0, 1'b1, 4'h0, 4'd2, '0, 1'b1);
        check("clr_rd_d", 0, dout_w[0], 32'h55);
        check("clr_ready", 0, 32'(ready_w[0]), 32'd0);
        wr(4'd1, 32'hFFFFFFFF, 4'hF);
        check("clr_rd_lat2", 1, dout_w[1], 32'h55);
        wait_ready(1, DEPTH);
        rd(4'd2);
        check("clr_zero", 0, dout_w[0], 32'h0);
        rd(4'd1);
        check("init_wr_drop", 0, dout_w[0], 32'h0);
        idle(); idle();

        // async reset in the middle of a fill
        cyc(1'b1, 1'b1, 4'h0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) idle();
        #2 rst_n0 = 1'b0;
        #1;
        check("midinit_ready", 0, 32'(ready_w[0]), 32'd0);
        check("midinit_ready", 2, 32'(ready_w[2]), 32'd1);
        check("midinit_done", 2, 32'(init_done_w[2]), 32'd1);
        @(negedge clk0);
        @(negedge clk0);
        rst_n0 = 1'b1;
        wait_ready(0, DEPTH);

        // async reset with a read in flight
        wr(4'd4, 32'h0BADF00D, 4'hF);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd4; clr0 = 1'b0;
        @(posedge clk0);
        #1 rst_n0 = 1'b0;
        csb0 = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("flight_v", k, 32'(dout_valid_w[k]), 32'd0);
            check("flight_d", k, dout_w[k], 32'h0);
        end
        @(negedge clk0);
        @(negedge clk0);
        rst_n0 = 1'b1;
        wait_ready(0, DEPTH);
        rd(4'd4);
        check("post_rst_zero", 0, dout_w[0], 32'h0);
        idle(); idle(); idle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
